// File: rtl/lcd_panel_responder_pkg.sv
// Shared constants, RAM-mode type and address helpers for the LCD panel responder.
// The visible DDRAM window is two 16-byte rows at 0x00..0x0F and 0x40..0x4F.
package lcd_panel_responder_pkg;

    localparam int         LCD_COLS       = 16;
    localparam logic [6:0] LCD_LINE2_BASE = 7'h40;
    localparam logic [6:0] LCD_LINE1_LAST = 7'h0F;
    localparam logic [6:0] LCD_LINE2_LAST = 7'h4F;
    localparam logic [7:0] LCD_SPACE      = 8'h20;

    typedef enum logic {
        MODE_DDRAM = 1'b0,
        MODE_CGRAM = 1'b1
    } ram_mode_t;

    function automatic logic ddram_valid(input logic [6:0] a);
        return (a <= LCD_LINE1_LAST) || ((a >= LCD_LINE2_BASE) && (a <= LCD_LINE2_LAST));
    endfunction

    // Row 2 is packed directly after row 1 in the 32-byte image.
    function automatic logic [4:0] ram_index(input logic [6:0] a);
        return 5'(a[6] ? (a - LCD_LINE2_BASE + 7'd16) : a);
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (a == LCD_LINE1_LAST)      n = LCD_LINE2_BASE;
            else if (a == LCD_LINE2_LAST) n = 7'h00;
            else                          n = a + 7'd1;
        end else begin
            if (a == 7'h00)               n = LCD_LINE2_LAST;
            else if (a == LCD_LINE2_BASE) n = LCD_LINE1_LAST;
            else                          n = a - 7'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/lcd_panel_responder_strobe_sync.sv
// Synchronises the E strobe and bus lines into mclk, detects the falling edge of E,
// measures the synced high width and holds the bus value seen while E was high.
module lcd_panel_responder_strobe_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_E_HIGH  = 1
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] db,
    output logic       e_sync,
    output logic       rs_sync,
    output logic       rw_sync,
    output logic       fall,
    output logic       high_ok,
    output logic       rs_cap,
    output logic       rw_cap,
    output logic [7:0] db_cap
);

    localparam logic [7:0] MIN_HIGH = 8'(MIN_E_HIGH);

    logic [SYNC_STAGES-1:0] e_pipe;
    logic [SYNC_STAGES-1:0] rs_pipe;
    logic [SYNC_STAGES-1:0] rw_pipe;
    logic [7:0]             db_pipe [SYNC_STAGES];
    logic                   e_prev;
    logic [7:0]             high_cnt;

    // Bus lines travel through the same depth as E so capture is aligned with the strobe.
    always_ff @(posedge mclk) begin
        if (rst) begin
            e_pipe   <= '0;
            rs_pipe  <= '0;
            rw_pipe  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) db_pipe[i] <= '0;
            e_prev   <= 1'b0;
            high_cnt <= '0;
            rs_cap   <= 1'b0;
            rw_cap   <= 1'b0;
            db_cap   <= '0;
        end else begin
            e_pipe[0]  <= e;
            rs_pipe[0] <= rs;
            rw_pipe[0] <= rw;
            db_pipe[0] <= db;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                e_pipe[i]  <= e_pipe[i-1];
                rs_pipe[i] <= rs_pipe[i-1];
                rw_pipe[i] <= rw_pipe[i-1];
                db_pipe[i] <= db_pipe[i-1];
            end
            e_prev <= e_sync;
            if (e_sync) begin
                rs_cap <= rs_pipe[SYNC_STAGES-1];
                rw_cap <= rw_pipe[SYNC_STAGES-1];
                db_cap <= db_pipe[SYNC_STAGES-1];
                if (high_cnt != 8'hFF) high_cnt <= high_cnt + 8'd1;
            end else begin
                high_cnt <= '0;
            end
        end
    end

    assign e_sync  = e_pipe[SYNC_STAGES-1];
    assign rs_sync = rs_pipe[SYNC_STAGES-1];
    assign rw_sync = rw_pipe[SYNC_STAGES-1];
    assign fall    = !e_sync && e_prev;
    assign high_ok = (high_cnt >= MIN_HIGH);

endmodule

// File: rtl/lcd_panel_responder.sv
// HD44780-style panel model: decodes bus transfers on the falling edge of E, keeps the
// 2x16 DDRAM image, address counter, display state and the busy flag.
module lcd_panel_responder
    import lcd_panel_responder_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1600,
    parameter int MIN_E_HIGH   = 1
) (
    input  logic         mclk,
    input  logic         rst,
    input  logic         E,
    input  logic         RS,
    input  logic         RW,
    input  logic [7:0]   DB_in,
    output logic [7:0]   DB_out,
    output logic         DB_oe,
    output logic [127:0] line_a,
    output logic [127:0] line_b,
    output logic [6:0]   cursor_addr,
    output logic         disp_on,
    output logic         cursor_on,
    output logic         blink_on,
    output logic         two_line,
    output logic         init_done,
    output logic         busy,
    output logic         protocol_err
);

    // mode       | meaning
    // MODE_DDRAM | data writes land in the display image at AC
    // MODE_CGRAM | data writes are accepted (busy applies) but dropped

    localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES);

    logic          e_sync, rs_sync, rw_sync, fall, high_ok;
    logic          rs_cap, rw_cap;
    logic [7:0]    db_cap;
    logic [7:0]    ddram [2*LCD_COLS];
    logic [CW-1:0] busy_cnt;
    logic          entry_inc;
    ram_mode_t     mode;
    logic          wr_req, rd_req, bad_addr, reject, accept_wr;

    lcd_panel_responder_strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_E_HIGH  (MIN_E_HIGH)
    ) u_strobe (
        .mclk    (mclk),
        .rst     (rst),
        .e       (E),
        .rs      (RS),
        .rw      (RW),
        .db      (DB_in),
        .e_sync  (e_sync),
        .rs_sync (rs_sync),
        .rw_sync (rw_sync),
        .fall    (fall),
        .high_ok (high_ok),
        .rs_cap  (rs_cap),
        .rw_cap  (rw_cap),
        .db_cap  (db_cap)
    );

    assign busy      = (busy_cnt != '0);
    assign wr_req    = fall && !rw_cap;
    assign rd_req    = fall && rw_cap;
    assign bad_addr  = !rs_cap && db_cap[7] && !ddram_valid(db_cap[6:0]);
    assign reject    = wr_req && (busy || !high_ok || (rs_cap && !init_done) || bad_addr);
    assign accept_wr = wr_req && !reject;

    always_ff @(posedge mclk) begin
        if (rst) begin
            for (int i = 0; i < 2*LCD_COLS; i++) ddram[i] <= LCD_SPACE;
            cursor_addr  <= '0;
            entry_inc    <= 1'b1;
            disp_on      <= 1'b0;
            cursor_on    <= 1'b0;
            blink_on     <= 1'b0;
            two_line     <= 1'b0;
            init_done    <= 1'b0;
            busy_cnt     <= '0;
            protocol_err <= 1'b0;
            mode         <= MODE_DDRAM;
        end else begin
            protocol_err <= reject;
            if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;

            if (accept_wr) begin
                busy_cnt <= BUSY_LOAD;
                if (rs_cap) begin
                    if (mode == MODE_DDRAM) begin
                        if (ddram_valid(cursor_addr)) ddram[ram_index(cursor_addr)] <= db_cap;
                        cursor_addr <= ac_step(cursor_addr, entry_inc);
                    end
                end else begin
                    casez (db_cap)
                        8'b1???????: begin
                            cursor_addr <= db_cap[6:0];
                            mode        <= MODE_DDRAM;
                        end
                        8'b01??????: mode <= MODE_CGRAM;
                        8'b001?????: begin
                            two_line <= db_cap[3];
                            if (db_cap[4]) init_done <= 1'b1;
                        end
                        8'b0001????: begin
                            if (!db_cap[3]) cursor_addr <= ac_step(cursor_addr, db_cap[2]);
                        end
                        8'b00001???: begin
                            disp_on   <= db_cap[2];
                            cursor_on <= db_cap[1];
                            blink_on  <= db_cap[0];
                        end
                        8'b000001??: entry_inc <= db_cap[1];
                        8'b0000001?: begin
                            cursor_addr <= '0;
                            mode        <= MODE_DDRAM;
                            busy_cnt    <= CLEAR_LOAD;
                        end
                        8'b00000001: begin
                            for (int i = 0; i < 2*LCD_COLS; i++) ddram[i] <= LCD_SPACE;
                            cursor_addr <= '0;
                            entry_inc   <= 1'b1;
                            mode        <= MODE_DDRAM;
                            busy_cnt    <= CLEAR_LOAD;
                        end
                        default: busy_cnt <= '0;
                    endcase
                end
            end

            if (rd_req && rs_cap) cursor_addr <= ac_step(cursor_addr, entry_inc);
        end
    end

    assign DB_oe = e_sync && rw_sync;

    always_comb begin
        DB_out = '0;
        if (DB_oe) DB_out = rs_sync ? ddram[ram_index(cursor_addr)] : {busy, cursor_addr};
    end

    always_comb begin
        line_a = '0;
        line_b = '0;
        for (int k = 0; k < LCD_COLS; k++) begin
            line_a[8*k +: 8] = ddram[k];
            line_b[8*k +: 8] = ddram[LCD_COLS + k];
        end
    end

endmodule

// File: tb/tb_lcd_panel_responder.sv
// Bench for lcd_panel_responder: directed bring-up sequences plus randomized bus traffic,
// compared every cycle against a flat-memory model with busy tracked as an end-cycle number.
module tb_lcd_panel_responder;

    localparam int SYNC = 2;
    localparam int BUSY = 40;
    localparam int CLR  = 1600;
    localparam int MINH = 1;

    logic         mclk = 1'b0;
    logic         rst, E, RS, RW;
    logic [7:0]   DB_in;
    logic [7:0]   DB_out;
    logic         DB_oe;
    logic [127:0] line_a, line_b;
    logic [6:0]   cursor_addr;
    logic         disp_on, cursor_on, blink_on, two_line, init_done, busy, protocol_err;

    always #5 mclk = ~mclk;

    lcd_panel_responder #(
        .SYNC_STAGES (SYNC),
        .BUSY_CYCLES (BUSY),
        .CLEAR_CYCLES(CLR),
        .MIN_E_HIGH  (MINH)
    ) dut (
        .mclk        (mclk),
        .rst         (rst),
        .E           (E),
        .RS          (RS),
        .RW          (RW),
        .DB_in       (DB_in),
        .DB_out      (DB_out),
        .DB_oe       (DB_oe),
        .line_a      (line_a),
        .line_b      (line_b),
        .cursor_addr (cursor_addr),
        .disp_on     (disp_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .two_line    (two_line),
        .init_done   (init_done),
        .busy        (busy),
        .protocol_err(protocol_err)
    );

    // model state: flat 128-byte address space, busy as "busy until cycle busy_end"
    logic [7:0] mram [128];
    int  m_ac;
    bit  m_id, m_d, m_c, m_b, m_n, m_init, m_cg;
    int  busy_end, err_cyc, cyc;
    bit  pend;
    int  pend_u, p_hold;
    bit  p_rs, p_rw;
    logic [7:0] p_d;

    int  checks = 0, errors = 0, nprint = 0, err_pulses = 0;
    bit  chk_en = 0, rd_chk = 0, idle_chk = 0;

    function automatic int step_ac(input int a, input bit inc);
        if (inc) return (a == 15) ? 64 : (a == 79) ? 0 : a + 1;
        return (a == 0) ? 79 : (a == 64) ? 15 : a - 1;
    endfunction

    function automatic bit addr_ok(input int a);
        return (a < 16) || (a >= 64 && a < 80);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 128; i++) mram[i] = 8'h20;
        m_ac = 0; m_id = 1; m_d = 0; m_c = 0; m_b = 0; m_n = 0; m_init = 0; m_cg = 0;
        busy_end = 0; err_cyc = -1; pend = 0;
    endtask

    task automatic model_apply();
        int u, load;
        u = cyc;
        if (p_rw) begin
            if (p_rs) m_ac = step_ac(m_ac, m_id);
            return;
        end
        if ((u - 1) < busy_end || p_hold < MINH || (p_rs && !m_init) ||
            (!p_rs && p_d[7] && !addr_ok(int'(p_d[6:0])))) begin
            err_cyc = u;
            return;
        end
        load = BUSY;
        if (p_rs) begin
            if (!m_cg) begin
                if (addr_ok(m_ac)) mram[m_ac] = p_d;
                m_ac = step_ac(m_ac, m_id);
            end
        end else if (p_d[7]) begin
            m_ac = int'(p_d[6:0]); m_cg = 0;
        end else if (p_d[6]) m_cg = 1;
        else if (p_d[5]) begin
            m_n = p_d[3];
            if (p_d[4]) m_init = 1;
        end else if (p_d[4]) begin
            if (!p_d[3]) m_ac = step_ac(m_ac, p_d[2]);
        end else if (p_d[3]) begin
            m_d = p_d[2]; m_c = p_d[1]; m_b = p_d[0];
        end else if (p_d[2]) m_id = p_d[1];
        else if (p_d[1]) begin
            m_ac = 0; m_cg = 0; load = CLR;
        end else if (p_d[0]) begin
            for (int i = 0; i < 128; i++) mram[i] = 8'h20;
            m_ac = 0; m_id = 1; m_cg = 0; load = CLR;
        end else load = 0;
        if (load > 0) busy_end = u + load;
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
        cyc++;
        if (pend && cyc == pend_u) begin
            model_apply();
            pend = 0;
        end
    endtask

    task automatic fld(input string nm, input logic [127:0] act, input logic [127:0] exp, inout bit bad);
        if (act !== exp) begin
            bad = 1;
            if (nprint < 40) $display("FAIL %s cyc %0d got %0h exp %0h", nm, cyc, act, exp);
            nprint++;
        end
    endtask

    always @(negedge mclk) begin
        logic [127:0] ea, eb;
        logic [7:0]   erd;
        bit bad, eb_busy;
        if (protocol_err === 1'b1) err_pulses++;
        if (chk_en) begin
            bad = 0;
            for (int k = 0; k < 16; k++) begin
                ea[8*k +: 8] = mram[k];
                eb[8*k +: 8] = mram[64 + k];
            end
            eb_busy = (cyc < busy_end);
            fld("line_a", line_a, ea, bad);
            fld("line_b", line_b, eb, bad);
            fld("cursor_addr", 128'(cursor_addr), 128'(m_ac), bad);
            fld("disp_on", 128'(disp_on), 128'(m_d), bad);
            fld("cursor_on", 128'(cursor_on), 128'(m_c), bad);
            fld("blink_on", 128'(blink_on), 128'(m_b), bad);
            fld("two_line", 128'(two_line), 128'(m_n), bad);
            fld("init_done", 128'(init_done), 128'(m_init), bad);
            fld("busy", 128'(busy), 128'(eb_busy), bad);
            fld("protocol_err", 128'(protocol_err), 128'(cyc == err_cyc), bad);
            if (rd_chk) begin
                erd = RS ? mram[m_ac] : {eb_busy, 7'(m_ac)};
                fld("rd_oe", 128'(DB_oe), 128'(1), bad);
                fld("rd_data", 128'(DB_out), 128'(erd), bad);
            end
            if (idle_chk) begin
                fld("idle_oe", 128'(DB_oe), 128'(0), bad);
                fld("idle_data", 128'(DB_out), 128'(0), bad);
            end
            checks++;
            if (bad) errors++;
        end
    end

    task automatic lit(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, act, exp);
        end
    endtask

    task automatic xfer(input bit rs_i, input bit rw_i, input logic [7:0] d, input int hold,
                        output logic [7:0] rv, output logic roe);
        idle_chk = 0;
        rv = '0; roe = 1'b0;
        RS = rs_i; RW = rw_i; DB_in = d; E = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (rw_i && i >= SYNC) rd_chk = 1;
            if (i == hold - 1) begin rv = DB_out; roe = DB_oe; end
        end
        rd_chk = 0;
        E = 1'b0;
        pend = 1; pend_u = cyc + SYNC + 1;
        p_rs = rs_i; p_rw = rw_i; p_d = d; p_hold = hold;
        repeat (SYNC + 1) tick();
        idle_chk = 1;
    endtask

    task automatic wait_idle();
        while (cyc < busy_end) tick();
    endtask

    task automatic wr(input bit rs_i, input logic [7:0] d);
        logic [7:0] rv; logic roe;
        wait_idle();
        xfer(rs_i, 1'b0, d, 2, rv, roe);
    endtask

    initial begin
        logic [7:0] rv;
        logic roe;
        int e0, u_clr, r, hold;
        logic [7:0] d;

        rst = 1; E = 0; RS = 0; RW = 0; DB_in = 0; cyc = 0;
        m_reset();
        repeat (3) tick();
        lit("rst_line_a", line_a, {16{8'h20}});
        lit("rst_line_b", line_b, {16{8'h20}});
        lit("rst_ac", 128'(cursor_addr), 128'(0));
        lit("rst_flags", 128'({disp_on, cursor_on, blink_on, two_line, init_done, busy, protocol_err, DB_oe}), 128'(0));
        lit("rst_db_out", 128'(DB_out), 128'(0));
        rst = 0;
        chk_en = 1; idle_chk = 1;
        tick();

        // bring-up
        e0 = err_pulses;
        wr(0, 8'h38); wr(0, 8'h0F); wr(0, 8'h06);
        tick();
        lit("init_state", 128'({two_line, init_done, disp_on, cursor_on, blink_on}), 128'(5'b11111));
        lit("init_no_err", 128'(err_pulses - e0), 128'(0));

        wr(0, 8'h80); wr(1, 8'h53); wr(1, 8'h75); wr(1, 8'h6E);
        lit("sun_text", 128'(line_a[23:0]), 128'(24'h6E7553));
        lit("sun_ac", 128'(cursor_addr), 128'(3));
        lit("sun_line_b", line_b, {16{8'h20}});

        wr(0, 8'hCF); wr(1, 8'h58); wr(1, 8'h59);
        lit("wrap_line_b", 128'(line_b[127:120]), 128'(8'h58));
        lit("wrap_line_a", 128'(line_a[7:0]), 128'(8'h59));
        lit("wrap_ac", 128'(cursor_addr), 128'(1));

        // write while busy is rejected
        e0 = err_pulses;
        xfer(1, 0, 8'h5A, 2, rv, roe);
        tick();
        lit("busy_rej_err", 128'(err_pulses - e0), 128'(1));
        lit("busy_rej_ram", 128'(line_a[15:8]), 128'(8'h75));
        lit("busy_rej_ac", 128'(cursor_addr), 128'(1));

        wr(0, 8'h01);
        u_clr = cyc;
        lit("clear_busy", 128'(busy), 128'(1));
        lit("clear_lines", {line_a, line_b} == {32{8'h20}} ? 128'(1) : 128'(0), 128'(1));
        lit("clear_ac", 128'(cursor_addr), 128'(0));
        xfer(0, 1, 8'h00, 3, rv, roe);
        lit("status_oe", 128'(roe), 128'(1));
        lit("status_val", 128'(rv), 128'(8'h80));
        while (busy === 1'b1 && cyc < u_clr + 2000) tick();
        lit("clear_busy_len", 128'(cyc - u_clr), 128'(1600));

        e0 = err_pulses;
        wr(0, 8'h9A);
        tick();
        lit("bad_addr_err", 128'(err_pulses - e0), 128'(1));
        lit("bad_addr_ac", 128'(cursor_addr), 128'(0));

        // decrement wrap, shift wrap, data read
        wr(0, 8'h04); wr(0, 8'h80); wr(1, 8'h71);
        lit("dec_wrap_ac", 128'(cursor_addr), 128'(7'h4F));
        wr(0, 8'h14);
        lit("shift_wrap_ac", 128'(cursor_addr), 128'(0));
        wr(0, 8'h06); wr(0, 8'h80);
        xfer(1, 1, 8'h00, 3, rv, roe);
        lit("data_read", 128'(rv), 128'(8'h71));
        lit("data_read_ac", 128'(cursor_addr), 128'(1));

        // reset during busy aborts everything
        wr(0, 8'h01);
        chk_en = 0; rst = 1;
        tick(); tick();
        m_reset();
        lit("rst_busy_abort", 128'({busy, init_done, cursor_addr}), 128'(0));
        rst = 0; chk_en = 1;

        // reset coinciding with the fall cycle loses the transfer
        idle_chk = 0;
        RS = 0; RW = 0; DB_in = 8'h0C; E = 1;
        tick(); tick();
        E = 0;
        tick(); tick();
        chk_en = 0; rst = 1;
        tick();
        rst = 0; m_reset(); chk_en = 1;
        repeat (4) tick();
        idle_chk = 1;
        lit("rst_fall_lost", 128'({disp_on, protocol_err}), 128'(0));

        wr(0, 8'h38); wr(0, 8'h0C); wr(0, 8'h06);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 1) wait_idle();
            else repeat ($urandom_range(0, 6)) tick();
            r = $urandom_range(0, 99);
            hold = $urandom_range(1, 4);
            d = 8'($urandom);
            if (r < 40)       xfer(1, 0, 8'($urandom_range(32, 126)), hold, rv, roe);
            else if (r < 50)  xfer(0, 0, 8'h80 | d, hold, rv, roe);
            else if (r < 55)  xfer(0, 0, 8'h10 | (d & 8'h0F), hold, rv, roe);
            else if (r < 60)  xfer(0, 0, 8'h08 | (d & 8'h07), hold, rv, roe);
            else if (r < 65)  xfer(0, 0, 8'h04 | (d & 8'h03), hold, rv, roe);
            else if (r < 67)  xfer(0, 0, 8'h20 | (d & 8'h1F), hold, rv, roe);
            else if (r < 69)  xfer(0, 0, 8'h40 | (d & 8'h3F), hold, rv, roe);
            else if (r < 70)  xfer(0, 0, 8'h02 | (d & 8'h01), hold, rv, roe);
            else if (r < 71)  xfer(0, 0, 8'h01, hold, rv, roe);
            else if (r < 72)  xfer(0, 0, 8'h00, hold, rv, roe);
            else if (r < 86)  xfer(0, 1, d, hold + 2, rv, roe);
            else              xfer(1, 1, d, hold + 2, rv, roe);
        end
        wait_idle();
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
